// File: rtl/comp16_dma_pkg.sv
// Shared definitions for the RAM block-copy/fill engine: FSM state
// encoding, transfer-mode constants and a small state-class helper.
package comp16_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } dma_state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // True for the states that touch the RAM port (a transfer is in flight).
    function automatic logic is_xfer_state(input dma_state_e st);
        logic act;
        case (st)
            ST_RD:   act = 1'b1;
            ST_WR:   act = 1'b1;
            default: act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ram_dma_addr_gen.sv
// Address/length bookkeeping for the DMA engine: loadable source and
// destination pointers that wrap modulo 2**ADDR_W, and a remaining-words
// down-counter with a flag marking the final word of the transfer.
module ram_dma_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              step,
    input  logic              step_src,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [LEN_W-1:0]  remaining,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  rem_r;

    // Load operands on an accepted start; advance pointers and count down once per written word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r <= {ADDR_W{1'b0}};
            dst_r <= {ADDR_W{1'b0}};
            rem_r <= {LEN_W{1'b0}};
        end else if (load) begin
            src_r <= src_in;
            dst_r <= dst_in;
            rem_r <= len_in;
        end else if (step) begin
            dst_r <= dst_r + ADDR_ONE;
            rem_r <= rem_r - LEN_ONE;
            if (step_src) begin
                src_r <= src_r + ADDR_ONE;
            end else begin
                src_r <= src_r;
            end
        end else begin
            src_r <= src_r;
            dst_r <= dst_r;
            rem_r <= rem_r;
        end
    end

    assign src       = src_r;
    assign dst       = dst_r;
    assign remaining = rem_r;
    assign last      = (rem_r == LEN_ONE);

endmodule

// File: rtl/ram_dma_engine.sv
// Block-copy / block-fill engine mastering one port of a dual-port RAM.
// Copy alternates a read cycle and a write cycle per word (the RAM read
// value has one cycle of latency); fill writes one word per cycle.
// Optional feature macro: RAM_DMA_CHECKSUM_EN adds a running sum (csum)
// of every word written during the transfer.
module ram_dma_engine
    import comp16_dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] srcAdrs,
    input  logic [ADDR_W-1:0] dstAdrs,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fillVal,
    input  logic              abort,
    output logic [ADDR_W-1:0] ramAdrs,
    output logic [DATA_W-1:0] ramData,
    output logic              ramWE,
    input  logic [DATA_W-1:0] ramVal,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  remaining
`ifdef RAM_DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    dma_state_e        state_r;
    logic              mode_r;
    logic [DATA_W-1:0] fill_r;
    logic              busy_r;
    logic              done_r;
    logic              aborted_r;
    logic [ADDR_W-1:0] hold_adrs_r;

    logic              load_s;
    logic              step_s;
    logic              step_src_s;
    logic [ADDR_W-1:0] src_s;
    logic [ADDR_W-1:0] dst_s;
    logic              last_s;
    logic [ADDR_W-1:0] adrs_s;
    logic [DATA_W-1:0] wdata_s;
    logic              we_s;

    // A start is only honoured in IDLE; a write cycle advances the counters.
    assign load_s     = (state_r == ST_IDLE) && start;
    assign step_s     = (state_r == ST_WR);
    assign step_src_s = step_s && (mode_r == MODE_COPY);

    ram_dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .src_in    (srcAdrs),
        .dst_in    (dstAdrs),
        .len_in    (len),
        .step      (step_s),
        .step_src  (step_src_s),
        .src       (src_s),
        .dst       (dst_s),
        .remaining (remaining),
        .last      (last_s)
    );

    // RAM port decode from the state register only, so write enable cannot glitch.
    always_comb begin
        adrs_s  = hold_adrs_r;
        wdata_s = {DATA_W{1'b0}};
        we_s    = 1'b0;
        case (state_r)
            ST_RD: begin
                adrs_s = src_s;
            end
            ST_WR: begin
                adrs_s = dst_s;
                we_s   = 1'b1;
                if (mode_r == MODE_FILL) begin
                    wdata_s = fill_r;
                end else begin
                    wdata_s = ramVal;
                end
            end
            default: begin
                adrs_s = hold_adrs_r;
            end
        endcase
    end

    assign ramAdrs = adrs_s;
    assign ramData = wdata_s;
    assign ramWE   = we_s;

    // Remember the last driven address so the port stays put while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_adrs_r <= {ADDR_W{1'b0}};
        end else begin
            hold_adrs_r <= adrs_s;
        end
    end

    // Transfer sequencer with registered busy/done/aborted status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mode_r    <= MODE_COPY;
            fill_r    <= {DATA_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            // done trails FIN by one edge so it pulses for exactly one cycle
            done_r <= (state_r == ST_FIN);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        fill_r    <= fillVal;
                        aborted_r <= 1'b0;
                        if (len == {LEN_W{1'b0}}) begin
                            state_r <= ST_FIN;
                            busy_r  <= 1'b0;
                        end else if (mode == MODE_FILL) begin
                            state_r <= ST_WR;
                            busy_r  <= is_xfer_state(ST_WR);
                        end else begin
                            state_r <= ST_RD;
                            busy_r  <= is_xfer_state(ST_RD);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (abort) begin
                        state_r   <= ST_FIN;
                        busy_r    <= 1'b0;
                        aborted_r <= 1'b1;
                    end else begin
                        state_r <= ST_WR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_WR: begin
                    // the write of this cycle completes regardless of abort
                    if (abort) begin
                        state_r   <= ST_FIN;
                        busy_r    <= 1'b0;
                        aborted_r <= 1'b1;
                    end else if (last_s) begin
                        state_r <= ST_FIN;
                        busy_r  <= 1'b0;
                    end else if (mode_r == MODE_FILL) begin
                        state_r <= ST_WR;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RD;
                        busy_r  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign aborted = aborted_r;

`ifdef RAM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;

    // Running modulo-2**DATA_W sum of every word written in this transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            csum_r <= {DATA_W{1'b0}};
        end else if (we_s) begin
            csum_r <= csum_r + wdata_s;
        end else begin
            csum_r <= csum_r;
        end
    end

    assign csum = csum_r;
`endif

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine paired with a 1-cycle-latency RAM model.
module tb_ram_dma_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] srcAdrs;
    logic [15:0] dstAdrs;
    logic [15:0] len;
    logic [15:0] fillVal;
    logic        abort;
    logic [15:0] ramAdrs;
    logic [15:0] ramData;
    logic        ramWE;
    logic [15:0] ramVal;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] remaining;
`ifdef RAM_DMA_CHECKSUM_EN
    logic [15:0] csum;
`endif

    logic [15:0] mem [0:65535];
    int          wr_count = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    ram_dma_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .srcAdrs   (srcAdrs),
        .dstAdrs   (dstAdrs),
        .len       (len),
        .fillVal   (fillVal),
        .abort     (abort),
        .ramAdrs   (ramAdrs),
        .ramData   (ramData),
        .ramWE     (ramWE),
        .ramVal    (ramVal),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .remaining (remaining)
`ifdef RAM_DMA_CHECKSUM_EN
        ,
        .csum      (csum)
`endif
    );

    // Behavioural RAM port: registered read, synchronous write, write counter.
    always @(posedge clk) begin
        if (ramWE) begin
            mem[ramAdrs] <= ramData;
            wr_count     <= wr_count + 1;
        end
        ramVal <= mem[ramAdrs];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [15:0] f);
        @(negedge clk);
        start = 1'b1; mode = m; srcAdrs = s; dstAdrs = d; len = l; fillVal = f;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges counted after the start-sampling edge until done is seen (bounded).
    task automatic wait_done(input int budget, output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        srcAdrs = 16'h0; dstAdrs = 16'h0; len = 16'h0; fillVal = 16'h0;
        #23;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b want 0", aborted); end
        n_checks++; if (remaining !== 16'h0) begin n_fail++; $display("FAIL reset_remaining: got %h want 0000", remaining); end
        n_checks++; if (ramWE !== 1'b0 || ramData !== 16'h0 || ramAdrs !== 16'h0) begin
            n_fail++; $display("FAIL reset_port: we=%b data=%h adrs=%h want 0/0000/0000", ramWE, ramData, ramAdrs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_fill;
        int e; bit seen; int w0;
        mem[16'h0104] = 16'h1234;
        w0 = wr_count;
        launch(1'b1, 16'h0000, 16'h0100, 16'd4, 16'hBEEF);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %b want 1", busy); end
        wait_done(20, e, seen);
        n_checks++; if (!seen || e + 1 != 6) begin n_fail++; $display("FAIL fill_latency: seen=%0d cycles=%0d want 6", seen, e + 1); end
        n_checks++; if (aborted !== 1'b0 || remaining !== 16'h0) begin
            n_fail++; $display("FAIL fill_status: aborted=%b remaining=%h want 0/0000", aborted, remaining);
        end
        n_checks++; if (wr_count - w0 != 4) begin n_fail++; $display("FAIL fill_writes: got %0d want 4", wr_count - w0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem[16'h0100 + i] !== 16'hBEEF) begin
                n_fail++; $display("FAIL fill_data[%0d]: got %h want beef", i, mem[16'h0100 + i]);
            end
        end
        n_checks++; if (mem[16'h0104] !== 16'h1234) begin n_fail++; $display("FAIL fill_overrun: got %h want 1234", mem[16'h0104]); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL fill_done_width: got %b want 0", done); end
    endtask

    task automatic test_copy;
        int e; bit seen; int w0;
        mem[16'h0010] = 16'd1; mem[16'h0011] = 16'd2; mem[16'h0012] = 16'd3;
        for (int i = 0; i < 4; i++) mem[16'h0200 + i] = 16'h0000;
        w0 = wr_count;
        launch(1'b0, 16'h0010, 16'h0200, 16'd3, 16'hFFFF);
        wait_done(30, e, seen);
        n_checks++; if (!seen || e + 1 != 8) begin n_fail++; $display("FAIL copy_latency: seen=%0d cycles=%0d want 8", seen, e + 1); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem[16'h0200 + i] !== 16'(i + 1)) begin
                n_fail++; $display("FAIL copy_data[%0d]: got %h want %h", i, mem[16'h0200 + i], 16'(i + 1));
            end
        end
        n_checks++; if (mem[16'h0203] !== 16'h0000) begin n_fail++; $display("FAIL copy_overrun: got %h want 0000", mem[16'h0203]); end
        n_checks++; if (wr_count - w0 != 3) begin n_fail++; $display("FAIL copy_writes: got %0d want 3", wr_count - w0); end
`ifdef RAM_DMA_CHECKSUM_EN
        n_checks++; if (csum !== 16'd6) begin n_fail++; $display("FAIL copy_csum: got %h want 0006", csum); end
`endif
    endtask

    task automatic test_wrap;
        int e; bit seen; int w0;
        mem[16'hFFFE] = 16'h0; mem[16'hFFFF] = 16'h0; mem[16'h0000] = 16'h0; mem[16'h0001] = 16'h0;
        mem[16'h0002] = 16'h5A5A;
        w0 = wr_count;
        launch(1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'hCAFE);
        wait_done(20, e, seen);
        n_checks++; if (!seen || e + 1 != 6) begin n_fail++; $display("FAIL wrap_latency: seen=%0d cycles=%0d want 6", seen, e + 1); end
        n_checks++; if (mem[16'hFFFE] !== 16'hCAFE || mem[16'hFFFF] !== 16'hCAFE ||
                        mem[16'h0000] !== 16'hCAFE || mem[16'h0001] !== 16'hCAFE) begin
            n_fail++; $display("FAIL wrap_data: got %h %h %h %h want cafe x4",
                               mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]);
        end
        n_checks++; if (mem[16'h0002] !== 16'h5A5A) begin n_fail++; $display("FAIL wrap_overrun: got %h want 5a5a", mem[16'h0002]); end
        n_checks++; if (wr_count - w0 != 4) begin n_fail++; $display("FAIL wrap_writes: got %0d want 4", wr_count - w0); end
        n_checks++; if (ramAdrs !== 16'h0001 || ramWE !== 1'b0 || ramData !== 16'h0) begin
            n_fail++; $display("FAIL wrap_idle_port: adrs=%h we=%b data=%h want 0001/0/0000", ramAdrs, ramWE, ramData);
        end
    endtask

    task automatic test_zero_len;
        int e; bit seen; int w0;
        w0 = wr_count;
        launch(1'b1, 16'h0000, 16'h0300, 16'd0, 16'h1111);
        wait_done(10, e, seen);
        n_checks++; if (!seen || e != 1) begin n_fail++; $display("FAIL zero_latency: seen=%0d edges=%0d want 1", seen, e); end
        n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL zero_aborted: got %b want 0", aborted); end
        n_checks++; if (wr_count - w0 != 0) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", wr_count - w0); end
    endtask

    task automatic test_abort;
        int e; bit seen; int w0; int nw;
        for (int i = 0; i < 8; i++) begin
            mem[16'h0400 + i] = 16'h0100 + 16'(i);
            mem[16'h0500 + i] = 16'h0000;
        end
        w0 = wr_count;
        nw = 0;
        launch(1'b0, 16'h0400, 16'h0500, 16'd8, 16'h0000);
        for (int k = 0; k < 40 && nw < 3; k++) begin
            if (ramWE === 1'b1) nw++;
            if (nw < 3) begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++; if (nw != 3) begin n_fail++; $display("FAIL abort_reach: write cycles seen %0d want 3", nw); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done(10, e, seen);
        n_checks++; if (!seen || e != 1) begin n_fail++; $display("FAIL abort_done: seen=%0d edges=%0d want 1", seen, e); end
        n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b want 1", aborted); end
        n_checks++; if (remaining !== 16'd5) begin n_fail++; $display("FAIL abort_remaining: got %0d want 5", remaining); end
        n_checks++; if (wr_count - w0 != 3) begin n_fail++; $display("FAIL abort_writes: got %0d want 3", wr_count - w0); end
        n_checks++; if (mem[16'h0500] !== 16'h0100 || mem[16'h0501] !== 16'h0101 ||
                        mem[16'h0502] !== 16'h0102 || mem[16'h0503] !== 16'h0000) begin
            n_fail++; $display("FAIL abort_data: got %h %h %h %h want 0100 0101 0102 0000",
                               mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_hold: got %b want 1", aborted); end
        // abort together with start in IDLE: the start wins and clears aborted
        w0 = wr_count;
        @(negedge clk);
        start = 1'b1; abort = 1'b1; mode = 1'b1; dstAdrs = 16'h0600; len = 16'd2; fillVal = 16'h6666;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        wait_done(10, e, seen);
        n_checks++; if (!seen || aborted !== 1'b0 || wr_count - w0 != 2 || mem[16'h0601] !== 16'h6666) begin
            n_fail++; $display("FAIL start_wins: seen=%0d aborted=%b writes=%0d data=%h want 1/0/2/6666",
                               seen, aborted, wr_count - w0, mem[16'h0601]);
        end
    endtask

    task automatic test_back_to_back;
        int e; bit seen; int w0;
        mem[16'h0780] = 16'h0000;
        w0 = wr_count;
        launch(1'b1, 16'h0000, 16'h0700, 16'd3, 16'h7777);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; dstAdrs = 16'h0780; len = 16'd5; fillVal = 16'h9999;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, e, seen);
        n_checks++; if (!seen || wr_count - w0 != 3) begin n_fail++; $display("FAIL busy_start: seen=%0d writes=%0d want 1/3", seen, wr_count - w0); end
        n_checks++; if (mem[16'h0780] !== 16'h0000 || mem[16'h0702] !== 16'h7777) begin
            n_fail++; $display("FAIL busy_start_data: got %h %h want 0000 7777", mem[16'h0780], mem[16'h0702]);
        end
    endtask

    task automatic test_reset_mid;
        int e; bit seen; int w0; int w1;
        w0 = wr_count;
        launch(1'b1, 16'h0000, 16'h0800, 16'd10, 16'h3333);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ramWE !== 1'b0 || busy !== 1'b0 || remaining !== 16'h0) begin
            n_fail++; $display("FAIL rst_mid_state: we=%b busy=%b remaining=%h want 0/0/0000", ramWE, busy, remaining);
        end
        w1 = wr_count;
        n_checks++; if (w1 - w0 != 3) begin n_fail++; $display("FAIL rst_mid_written: got %0d want 3", w1 - w0); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (wr_count != w1) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d extra writes want 0", wr_count - w1); end
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_count;
        launch(1'b1, 16'h0000, 16'h0900, 16'd2, 16'h4242);
        wait_done(20, e, seen);
        n_checks++; if (!seen || e + 1 != 4 || wr_count - w0 != 2 ||
                        mem[16'h0900] !== 16'h4242 || mem[16'h0901] !== 16'h4242) begin
            n_fail++; $display("FAIL rst_mid_restart: seen=%0d cycles=%0d writes=%0d data=%h %h want 1/4/2/4242 4242",
                               seen, e + 1, wr_count - w0, mem[16'h0900], mem[16'h0901]);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_copy;
        test_wrap;
        test_zero_len;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
